// File: rtl/dcache_direct_wb.sv
// Direct-mapped, write-back, write-allocate data cache between the core's
// data port and a slow line-oriented main memory.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   proc_read, proc_write      word request from the core, held while stalled
//   proc_addr[29:0]            word address {tag, index, offset[1:0]}
//   proc_wdata[31:0]           store data
//   proc_stall                 request not completing this cycle
//   proc_rdata[31:0]           load data, valid when read and not stalled
//   mem_read, mem_write        line refill / line write-back request
//   mem_addr[27:0]             line address {tag, index}
//   mem_wdata[127:0]           victim line, word 0 in [31:0]
//   mem_ready                  one-cycle completion pulse from memory
//   mem_rdata[127:0]           refill line, valid with mem_ready
module dcache_direct_wb #(
  parameter int NUM_LINES = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic         mem_ready,
  input  logic [127:0] mem_rdata
);

  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = 28 - IW;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TW-1:0]        tags  [NUM_LINES];
  logic [127:0]         lines [NUM_LINES];

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [1:0]    off;
  logic [6:0]    bit_off;
  logic          req;
  logic          hit;
  logic          write_hit;
  logic          refill;
  logic [127:0]  line_cur;
  logic [127:0]  line_wr;

  assign off      = proc_addr[1:0];
  assign idx      = proc_addr[IW+1:2];
  assign tag      = proc_addr[29:IW+2];
  assign bit_off  = {off, 5'd0};
  assign req      = proc_read | proc_write;
  assign hit      = valid[idx] && (tags[idx] == tag);
  assign line_cur = lines[idx];

  assign proc_rdata = line_cur[bit_off +: 32];
  assign mem_wdata  = line_cur;
  assign proc_stall = req & ~((state == IDLE) & hit) & ~rst;

  // A simultaneous read and write is treated as a write.
  assign write_hit = proc_write & (state == IDLE) & hit & ~rst;
  assign refill    = (state == ALLOCATE) & mem_ready & ~rst;

  always_comb begin
    line_wr = line_cur;
    line_wr[bit_off +: 32] = proc_wdata;
  end

  always_comb begin
    state_nxt = state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = {tag, idx};
    case (state)
      IDLE: begin
        if (req && !hit) begin
          state_nxt = (valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_write = 1'b1;
        mem_addr  = {tags[idx], idx};
        if (mem_ready) begin
          state_nxt = ALLOCATE;
        end
      end
      ALLOCATE: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM plus per-line valid/dirty bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= state_nxt;
      if (refill) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end else if (write_hit) begin
        dirty[idx] <= 1'b1;
      end
    end
  end

  // Tag and data storage carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (refill) begin
      lines[idx] <= mem_rdata;
      tags[idx]  <= tag;
    end else if (write_hit) begin
      lines[idx] <= line_wr;
    end
  end

endmodule

// File: tb/tb_dcache_direct_wb.sv
// Scoreboard bench for dcache_direct_wb: directed scenarios followed by a
// randomized phase, checked against a flat-memory reference model.
module tb_dcache_direct_wb;

  logic         clk = 1'b0;
  logic         rst;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;

  always #5 clk = ~clk;

  dcache_direct_wb #(.NUM_LINES(8)) dut (
    .clk(clk), .rst(rst),
    .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_stall(proc_stall), .proc_rdata(proc_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  typedef struct { bit is_write; logic [31:0] rdata; int stall; } pexp_t;
  typedef struct { bit is_write; logic [27:0] addr; logic [127:0] data; } mexp_t;

  pexp_t pq[$];
  mexp_t mq[$];
  int compared   = 0;
  int mismatched = 0;

  // Backing memory (environment) and reference model state.
  logic [31:0] bmem [bit [29:0]];
  logic [31:0] view [bit [29:0]];
  logic [31:0] rmem [bit [29:0]];
  logic [24:0] rtag   [8];
  bit          rvalid [8];
  bit          rdirty [8];

  int          mem_lat = 0;
  int          cnt     = 0;
  int          wb_cnt  = 0;
  int          rd_cnt  = 0;
  logic [27:0] last_wb_addr = '0;
  logic [27:0] last_rd_addr = '0;
  logic [127:0] last_wb_data = '0;
  logic [31:0] last_rdata = '0;
  int          last_stall = 0;
  int          stall_cnt  = 0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void flag(string name);
    compared++;
    mismatched++;
    $display("FAIL %s", name);
  endfunction

  function automatic logic [31:0] init_word(logic [29:0] a);
    logic [31:0] ln;
    ln = {4'h0, a[29:2]} - 32'd1;
    return (32'h11111111 * {30'd0, a[1:0]}) ^ (ln * 32'h9E3779B1);
  endfunction

  function automatic logic [31:0] bget(logic [29:0] a);
    if (bmem.exists(a)) return bmem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] vget(logic [29:0] a);
    if (view.exists(a)) return view[a];
    return init_word(a);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      rvalid[i] = 1'b0;
      rdirty[i] = 1'b0;
    end
    view = rmem;
  endfunction

  // Predict the outcome of one processor access and queue expectations.
  function automatic void model_access(bit isw, logic [29:0] a, logic [31:0] d, int w);
    logic [2:0]   ix;
    logic [24:0]  tg;
    logic [1:0]   kk;
    logic [29:0]  wa;
    logic [127:0] ln;
    bit           hit;
    int           st;
    mexp_t        m;
    pexp_t        p;
    ix  = a[4:2];
    tg  = a[29:5];
    hit = rvalid[ix] && (rtag[ix] == tg);
    st  = 0;
    if (!hit) begin
      if (rvalid[ix] && rdirty[ix]) begin
        for (int k = 0; k < 4; k++) begin
          kk = k[1:0];
          wa = {rtag[ix], ix, kk};
          ln[k*32 +: 32] = vget(wa);
          rmem[wa] = vget(wa);
        end
        m.is_write = 1'b1;
        m.addr = {rtag[ix], ix};
        m.data = ln;
        mq.push_back(m);
        st = 2 * w + 3;
      end else begin
        st = w + 2;
      end
      m.is_write = 1'b0;
      m.addr = a[29:2];
      m.data = '0;
      mq.push_back(m);
      rtag[ix]   = tg;
      rvalid[ix] = 1'b1;
      rdirty[ix] = 1'b0;
    end
    if (isw) begin
      view[a]    = d;
      rdirty[ix] = 1'b1;
    end
    p.is_write = isw;
    p.rdata    = vget(a);
    p.stall    = st;
    pq.push_back(p);
  endfunction

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  endtask

  // Processor-side monitor.
  always @(negedge clk) begin : mon
    pexp_t p;
    if (rst) begin
      stall_cnt = 0;
    end else if (proc_read || proc_write) begin
      if (proc_stall) begin
        stall_cnt++;
      end else begin
        if (pq.size() == 0) begin
          flag("unexpected_completion");
        end else begin
          p = pq.pop_front();
          check("stall_cycles", 128'(stall_cnt), 128'(p.stall));
          if (!p.is_write) check("rdata", 128'(proc_rdata), 128'(p.rdata));
          last_rdata = proc_rdata;
          last_stall = stall_cnt;
        end
        stall_cnt = 0;
      end
    end
  end

  // Memory responder and memory-side monitor.
  always @(negedge clk) begin : resp
    mexp_t        m;
    logic [127:0] ln;
    logic [1:0]   kk;
    if (rst) begin
      mem_ready = 1'b0;
      cnt = 0;
    end else begin
      if (mem_ready) begin
        mem_ready = 1'b0;
        cnt = 0;
      end
      if (mem_read && mem_write) flag("mem_read_and_write");
      if (mem_read || mem_write) begin
        if (cnt == 0) begin
          if (mem_write) begin
            wb_cnt++;
            last_wb_addr = mem_addr;
            last_wb_data = mem_wdata;
          end else begin
            rd_cnt++;
            last_rd_addr = mem_addr;
          end
          if (mq.size() == 0) begin
            flag("unexpected_mem_request");
          end else begin
            m = mq.pop_front();
            check("mem_kind", 128'(mem_write), 128'(m.is_write));
            check("mem_addr", 128'(mem_addr), 128'(m.addr));
            if (m.is_write) check("wb_data", mem_wdata, m.data);
          end
        end
        if (cnt >= mem_lat) begin
          for (int k = 0; k < 4; k++) begin
            kk = k[1:0];
            if (mem_write) bmem[{mem_addr, kk}] = mem_wdata[k*32 +: 32];
            else ln[k*32 +: 32] = bget({mem_addr, kk});
          end
          if (!mem_write) mem_rdata = ln;
          mem_ready = 1'b1;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Issue one request at posedge+1 and return at posedge+1 after completion.
  task automatic do_req(bit isw, logic [29:0] a, logic [31:0] d, int w);
    int n;
    model_access(isw, a, d, w);
    mem_lat    = w;
    proc_read  = !isw;
    proc_write = isw;
    proc_addr  = a;
    proc_wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (proc_stall && n < 200);
    if (proc_stall) begin
      flag("request_timeout");
      finish_run();
    end
    @(posedge clk);
    #1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int txn;
    mexp_t m;
    logic [29:0] a;
    rst = 1'b1;
    proc_read = 1'b1;
    proc_write = 1'b0;
    proc_addr = 30'h5;
    proc_wdata = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;

    // Reset state.
    @(negedge clk);
    check("stall_during_reset", 128'(proc_stall), 128'd0);
    @(posedge clk);
    #1;
    check("reset_mem_read", 128'(mem_read), 128'd0);
    check("reset_mem_write", 128'(mem_write), 128'd0);
    do_reset();

    // Clean read miss.
    do_req(1'b0, 30'h5, 32'h0, 2);
    check("clean_miss_rdata", 128'(last_rdata), 128'h11111111);
    check("clean_miss_stall", 128'(last_stall), 128'd4);
    check("clean_miss_addr", 128'(last_rd_addr), 128'h1);

    // Write hit then read back.
    do_req(1'b1, 30'h5, 32'hDEADBEEF, 0);
    check("write_hit_stall", 128'(last_stall), 128'd0);
    do_req(1'b0, 30'h5, 32'h0, 0);
    check("read_after_write", 128'(last_rdata), 128'hDEADBEEF);

    // Dirty eviction.
    do_req(1'b0, 30'h25, 32'h0, 1);
    check("evict_wb_addr", 128'(last_wb_addr), 128'h1);
    check("evict_wb_data", last_wb_data, 128'h33333333_22222222_DEADBEEF_00000000);
    check("evict_rd_addr", 128'(last_rd_addr), 128'h9);
    check("evict_rdata", 128'(last_rdata), 128'hE0AADC99);

    // Write miss allocate, then eviction of the now-dirty line.
    txn = wb_cnt;
    do_req(1'b1, 30'h10, 32'hCAFEF00D, 1);
    check("wmiss_no_wb", 128'(wb_cnt), 128'(txn));
    check("wmiss_rd_addr", 128'(last_rd_addr), 128'h4);
    do_req(1'b0, 30'h30, 32'h0, 0);
    check("wmiss_evict_wb", 128'(wb_cnt), 128'(txn + 1));
    check("wmiss_evict_addr", 128'(last_wb_addr), 128'h4);

    // Streaming hits across all lines.
    for (int i = 0; i < 8; i++) do_req(1'b0, 30'(i * 4), 32'h0, 0);
    txn = wb_cnt + rd_cnt;
    for (int i = 0; i < 8; i++) do_req(1'b0, 30'(i * 4 + (i % 4)), 32'h0, 0);
    check("stream_no_mem", 128'(wb_cnt + rd_cnt), 128'(txn));

    // Reset in the middle of a refill.
    do_reset();
    m.is_write = 1'b0;
    m.addr = 28'h10;
    m.data = '0;
    mq.push_back(m);
    mem_lat = 50;
    proc_read = 1'b1;
    proc_addr = 30'h40;
    repeat (3) @(posedge clk);
    #1;
    check("refill_pending", 128'(mem_read), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    check("stall_in_reset", 128'(proc_stall), 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    proc_read = 1'b0;
    check("mem_read_dropped", 128'(mem_read), 128'd0);
    model_reset();
    txn = rd_cnt;
    do_req(1'b0, 30'h40, 32'h0, 1);
    check("fresh_refill", 128'(rd_cnt), 128'(txn + 1));
    check("fresh_refill_addr", 128'(last_rd_addr), 128'h10);

    // Randomized traffic over four tags per index.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      a = 30'($urandom_range(0, 127));
      do_req(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    check("proc_queue_drained", 128'(pq.size()), 128'd0);
    check("mem_queue_drained", 128'(mq.size()), 128'd0);
    finish_run();
  end

endmodule
